// File: rtl/pc_unit.sv
//------------------------------------------------------------------------------
// pc_unit : program counter with branch/jump target selection, exception
//           redirect and a circular return-address stack for RET prediction.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
  parameter int               RAS_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             exc_req,
  input  logic [2:0]                       jump_mode,
  input  logic [1:0]                       alu_comp_result,
  input  logic [15:0]                      num,
  input  logic [25:0]                      jnum,
  input  logic [WIDTH-1:0]                 reg_,
  output logic [WIDTH-1:0]                 pc,
  output logic [WIDTH-1:0]                 next_pc,
  output logic [WIDTH-1:0]                 link_addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_hit,
  output logic                             ras_miss
);

  localparam int C_CW = $clog2(RAS_DEPTH + 1);
  localparam int C_PW = $clog2(RAS_DEPTH);

  localparam logic [C_CW-1:0] C_FULL = C_CW'(RAS_DEPTH);

  localparam logic [2:0] C_SEQ = 3'd0;
  localparam logic [2:0] C_BEQ = 3'd1;
  localparam logic [2:0] C_BNE = 3'd2;
  localparam logic [2:0] C_JR  = 3'd3;
  localparam logic [2:0] C_J   = 3'd4;
  localparam logic [2:0] C_JAL = 3'd5;
  localparam logic [2:0] C_RET = 3'd6;

  logic [WIDTH-1:0] r_pc;
  logic [C_PW-1:0]  r_sp;
  logic [C_CW-1:0]  r_count;
  logic             r_hit;
  logic             r_miss;
  logic [WIDTH-1:0] r_mem [RAS_DEPTH];

  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_offset;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_j_tgt;
  logic [WIDTH-1:0] w_next;
  logic [C_PW-1:0]  w_sp_dec;
  logic [WIDTH-1:0] w_top;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;

  assign w_pc4    = r_pc + WIDTH'(4);
  assign w_offset = {{(WIDTH-18){num[15]}}, num, 2'b00};
  assign w_br_tgt = w_pc4 + w_offset;
  assign w_j_tgt  = {w_pc4[WIDTH-1:28], jnum, 2'b00};

  always_comb begin
    w_next = w_pc4;
    if (exc_req) begin
      w_next = EXC_VECTOR;
    end else begin
      case (jump_mode)
        C_BEQ:       if (alu_comp_result == 2'b00) w_next = w_br_tgt;
        C_BNE:       if (alu_comp_result != 2'b00) w_next = w_br_tgt;
        C_JR, C_RET: w_next = reg_;
        C_J, C_JAL:  w_next = w_j_tgt;
        default:     w_next = w_pc4;
      endcase
    end
  end

  // Stack only moves on cycles where the instruction actually retires.
  assign w_accept = !stall && !exc_req;
  assign w_push   = w_accept && (jump_mode == C_JAL);
  assign w_pop    = w_accept && (jump_mode == C_RET);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_FULL);
  assign w_sp_dec = r_sp - C_PW'(1);
  assign w_top    = r_mem[w_sp_dec];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_sp    <= '0;
      r_count <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (exc_req) begin
        r_pc <= EXC_VECTOR;
      end else if (!stall) begin
        r_pc <= w_next;
      end
      // A full stack wraps the pointer onto the oldest entry.
      if (w_push) begin
        r_sp <= r_sp + C_PW'(1);
        if (!w_full) r_count <= r_count + C_CW'(1);
      end else if (w_pop) begin
        if (!w_empty) begin
          r_sp    <= w_sp_dec;
          r_count <= r_count - C_CW'(1);
          r_hit   <= (w_top == reg_);
          r_miss  <= (w_top != reg_);
        end else begin
          r_miss  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_sp] <= w_pc4;
  end

  assign pc        = r_pc;
  assign next_pc   = w_next;
  assign link_addr = w_pc4;
  assign ras_count = r_count;
  assign ras_hit   = r_hit;
  assign ras_miss  = r_miss;

endmodule

`default_nettype wire
